// File: rtl/softmax_sched_if.sv
// Bus bundle between the softmax scheduler, its upstream row producer,
// the softmax core and the downstream result consumer.
// The slave view belongs to the scheduler. The master view belongs to whatever surrounds it.
interface softmax_sched_if #(
    parameter int N     = 8,
    parameter int TAG_W = 4
);
    // Upstream score rows
    logic                 in_valid;
    logic                 in_ready;
    logic [N*16-1:0]      in_x_flat;
    logic [TAG_W-1:0]     in_tag;

    // Softmax core side
    logic                 sm_en;
    logic                 sm_valid_in;
    logic [N*16-1:0]      sm_x_flat;
    logic                 sm_valid_out;
    logic [N*16-1:0]      sm_prob_flat;

    // Downstream result consumer
    logic                 out_valid;
    logic                 out_ready;
    logic [N*16-1:0]      out_prob_flat;
    logic [TAG_W-1:0]     out_tag;

    modport slave (
        input  in_valid, in_x_flat, in_tag,
        input  sm_valid_out, sm_prob_flat,
        input  out_ready,
        output in_ready,
        output sm_en, sm_valid_in, sm_x_flat,
        output out_valid, out_prob_flat, out_tag
    );

    modport master (
        output in_valid, in_x_flat, in_tag,
        output sm_valid_out, sm_prob_flat,
        output out_ready,
        input  in_ready,
        input  sm_en, sm_valid_in, sm_x_flat,
        input  out_valid, out_prob_flat, out_tag
    );
endinterface

// File: rtl/softmax_sched.sv
// Row scheduler and flow controller for the N-lane softmax core.
// It accepts tagged score rows and issues each row to the core as a one-cycle pulse.
// Issue is credit-limited, so every returned result always has a slot in the in-order result FIFO.
// The result FIFO is first-word fall-through, and the consumer may back-pressure it.
module softmax_sched #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_flush,
    softmax_sched_if.slave  bus,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err_ovf
);

    localparam int XW = N * 16;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_sm_en;
    logic               r_done;
    logic               r_err_ovf;

    logic [CW-1:0]      r_inflight;
    logic [CW-1:0]      r_count;

    logic [PW-1:0]      r_tag_wr;
    logic [PW-1:0]      r_tag_rd;
    logic [PW-1:0]      r_res_wr;
    logic [PW-1:0]      r_res_rd;

    logic [TAG_W-1:0]   r_tag_mem  [DEPTH];
    logic [TAG_W-1:0]   r_res_tag  [DEPTH];
    logic [XW-1:0]      r_res_prob [DEPTH];

    logic               r_sm_valid_in;
    logic [XW-1:0]      r_sm_x;

    logic [CW:0]        w_occupied;
    logic               w_has_credit;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_return;
    logic               w_unexpected;
    logic               w_pop;
    logic               w_out_valid;
    logic               w_drained;

    // Pointers wrap at DEPTH, so any depth works, including depths that are not a power of two.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        if (p == LAST_P) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Credits are whatever is not already buffered or in flight.
    // in_ready never looks ahead at a same-cycle pop.
    assign w_occupied   = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_has_credit = (w_occupied < DEPTH_C);
    assign w_in_ready   = (r_state == S_RUN) && w_has_credit;

    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_return     = bus.sm_valid_out && (r_inflight != '0);
    assign w_unexpected = bus.sm_valid_out && (r_inflight == '0);
    assign w_out_valid  = (r_count != '0);
    assign w_pop        = w_out_valid && bus.out_ready;
    assign w_drained    = (r_inflight == '0) && (r_count == '0);

    assign bus.in_ready      = w_in_ready;
    assign bus.sm_en         = r_sm_en;
    assign bus.sm_valid_in   = r_sm_valid_in;
    assign bus.sm_x_flat     = r_sm_x;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_prob_flat = w_out_valid ? r_res_prob[r_res_rd] : '0;
    assign bus.out_tag       = w_out_valid ? r_res_tag[r_res_rd]  : '0;

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err_ovf = r_err_ovf;

    // Control FSM. busy, sm_en and the done pulse are registered together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_sm_en <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_sm_en <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_sm_en <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_sm_en <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy counters and FIFO pointers.
    // A simultaneous accept and return leaves inflight unchanged.
    // A simultaneous return and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_count    <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_res_wr   <= '0;
            r_res_rd   <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_accept) - CW'(w_return);
            r_count    <= r_count + CW'(w_return) - CW'(w_pop);
            if (w_accept) begin
                r_tag_wr <= nextPtr(r_tag_wr);
            end
            if (w_return) begin
                r_tag_rd <= nextPtr(r_tag_rd);
                r_res_wr <= nextPtr(r_res_wr);
            end
            if (w_pop) begin
                r_res_rd <= nextPtr(r_res_rd);
            end
        end
    end

    // Issue register: one-cycle valid pulse to the core; the row data holds its last value between issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sm_valid_in <= 1'b0;
            r_sm_x        <= '0;
        end else begin
            r_sm_valid_in <= w_accept;
            if (w_accept) begin
                r_sm_x <= bus.in_x_flat;
            end
        end
    end

    // Sticky flag for a core result that arrives with nothing in flight; that result is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
        end else if (w_unexpected) begin
            r_err_ovf <= 1'b1;
        end
    end

    // Tag and result storage. Validity comes only from the pointers and count, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_mem[r_tag_wr] <= bus.in_tag;
        end
        if (w_return) begin
            r_res_tag[r_res_wr]  <= r_tag_mem[r_tag_rd];
            r_res_prob[r_res_wr] <= bus.sm_prob_flat;
        end
    end

endmodule

// File: tb/tb_softmax_sched.sv
// Directed bench for softmax_sched.
// The bench plays both the upstream producer and an in-order softmax core.
// A reference model predicts the state, credits and occupancy.
// A scoreboard queue holds the expected {tag, prob} for every accepted row.
module tb_softmax_sched;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int XW    = N * 16;

    typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;

    logic clk;
    logic rst_n;
    logic start;
    logic flush;
    logic busy;
    logic done;
    logic errOvf;

    softmax_sched_if #(.N(N), .TAG_W(TAG_W)) bus ();

    softmax_sched #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (start),
        .i_flush   (flush),
        .bus       (bus),
        .o_busy    (busy),
        .o_done    (done),
        .o_err_ovf (errOvf)
    );

    int compared   = 0;
    int mismatched = 0;

    mstate_t             mState;
    int                  expInflight;
    int                  expCount;
    logic                expSmValid;
    logic                expDone;
    logic                expErr;
    logic [XW-1:0]       lastX;
    logic [TAG_W+XW-1:0] sb[$];
    logic [XW-1:0]       coreQ[$];
    int                  dutAccepts;
    int                  doneSeen;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model front end: capture every issued row once, half a cycle after it appears.
    always @(negedge clk) begin
        if (bus.sm_valid_in === 1'b1) begin
            coreQ.push_back(bus.sm_x_flat);
        end
    end

    // The core's transform: a fixed per-lane pattern, so returned data differs from issued data.
    function automatic logic [XW-1:0] fx(input logic [XW-1:0] x);
        logic [XW-1:0] k;
        k = {N{16'h5A3C}};
        return x ^ k;
    endfunction

    function automatic logic [XW-1:0] makeRow(input int seed);
        logic [XW-1:0] r;
        r = '0;
        for (int lane = 0; lane < N; lane++) begin
            r[lane*16 +: 16] = 16'(seed * 16 + lane + 1);
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mState      = M_IDLE;
        expInflight = 0;
        expCount    = 0;
        expSmValid  = 1'b0;
        expDone     = 1'b0;
        expErr      = 1'b0;
        lastX       = '0;
        sb.delete();
        coreQ.delete();
    endtask

    // One clock cycle: drive the inputs, check the outputs against the model, clock the edge, then advance the model.
    task automatic applyStimulus(input logic iv, input logic [TAG_W-1:0] tg, input logic [XW-1:0] x,
                                 input logic ret, input logic rdy, input logic st, input logic fl);
        logic [XW-1:0]       prob;
        logic [TAG_W+XW-1:0] head;
        logic                expReady;
        logic                acc;
        logic                retOk;
        logic                pop;
        @(negedge clk);
        #1;
        bus.in_valid  = iv;
        bus.in_tag    = tg;
        bus.in_x_flat = x;
        bus.out_ready = rdy;
        start         = st;
        flush         = fl;
        if (ret && coreQ.size() != 0) begin
            prob = fx(coreQ.pop_front());
        end else begin
            prob = {$urandom, $urandom, $urandom, $urandom};
        end
        bus.sm_valid_out = ret;
        bus.sm_prob_flat = prob;
        #1;
        expReady = (mState == M_RUN) && (expCount + expInflight < DEPTH);
        checkOutput("in_ready", XW'(bus.in_ready), XW'(expReady));
        checkOutput("sm_valid_in", XW'(bus.sm_valid_in), XW'(expSmValid));
        if (expSmValid) begin
            checkOutput("sm_x_flat", bus.sm_x_flat, lastX);
        end
        checkOutput("sm_en", XW'(bus.sm_en), XW'(mState != M_IDLE));
        checkOutput("busy", XW'(busy), XW'(mState != M_IDLE));
        checkOutput("done", XW'(done), XW'(expDone));
        checkOutput("err_ovf", XW'(errOvf), XW'(expErr));
        checkOutput("out_valid", XW'(bus.out_valid), XW'(expCount != 0));
        if (expCount != 0) begin
            head = sb[0];
            checkOutput("out_tag", XW'(bus.out_tag), XW'(head[TAG_W+XW-1:XW]));
            checkOutput("out_prob", bus.out_prob_flat, head[XW-1:0]);
        end
        if (iv && bus.in_ready) begin
            dutAccepts++;
        end
        if (done) begin
            doneSeen++;
        end
        acc   = iv && expReady;
        retOk = ret && (expInflight != 0);
        pop   = rdy && (expCount != 0);
        @(posedge clk);
        if (ret && expInflight == 0) begin
            expErr = 1'b1;
        end
        expDone = (mState == M_DRAIN) && (expInflight == 0) && (expCount == 0);
        case (mState)
            M_IDLE:  if (st) mState = M_RUN;
            M_RUN:   if (fl) mState = M_DRAIN;
            M_DRAIN: if (expDone) mState = M_IDLE;
            default: mState = M_IDLE;
        endcase
        if (pop) begin
            head = sb.pop_front();
        end
        if (acc) begin
            sb.push_back({tg, fx(x)});
            lastX = x;
        end
        expInflight = expInflight + int'(acc) - int'(retOk);
        expCount    = expCount + int'(retOk) - int'(pop);
        expSmValid  = acc;
    endtask

    task automatic idleStep(input logic ret, input logic rdy);
        applyStimulus(1'b0, '0, '0, ret, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        flush            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_tag       = '0;
        bus.in_x_flat    = '0;
        bus.out_ready    = 1'b0;
        bus.sm_valid_out = 1'b0;
        bus.sm_prob_flat = '0;
        dutAccepts       = 0;
        doneSeen         = 0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        idleStep(1'b0, 1'b0);

        // Single row: tag 3, all lanes 0x0100
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd3, {N{16'h0100}}, 1'b0, 1'b0, 1'b0, 1'b0);
        idleStep(1'b0, 1'b0);
        idleStep(1'b1, 1'b0);
        idleStep(1'b0, 1'b0);
        idleStep(1'b0, 1'b1);
        idleStep(1'b0, 1'b0);

        // Credit limit: six rows offered with the consumer stalled
        dutAccepts = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'(i + 8), makeRow(i + 8), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            idleStep(1'b1, 1'b0);
        end
        checkOutput("accepts_at_credit_limit", XW'(dutAccepts), XW'(4));
        applyStimulus(1'b1, 4'd12, makeRow(12), 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd12, makeRow(12), 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("accepts_after_pop", XW'(dutAccepts), XW'(5));
        for (int i = 0; i < 6; i++) begin
            idleStep(1'b1, 1'b1);
        end

        // Steady state: accept, return and pop in the same cycle
        for (int i = 0; i < 22; i++) begin
            applyStimulus(1'b1, 4'(i), makeRow(100 + i), (i >= 1), 1'b1, 1'b0, 1'b0);
        end
        idleStep(1'b1, 1'b1);
        idleStep(1'b0, 1'b1);
        idleStep(1'b0, 1'b1);

        // Flush with two rows in flight and one buffered
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'(i + 5), makeRow(200 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idleStep(1'b1, 1'b0);
        doneSeen = 0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 4'hF, makeRow(300 + k), (k < 2), 1'b1, 1'b0, 1'b0);
        end
        checkOutput("done_pulses", XW'(doneSeen), XW'(1));

        // Unexpected core result while nothing is in flight
        idleStep(1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idleStep(1'b0, 1'b0);
        idleStep(1'b0, 1'b0);
        idleStep(1'b0, 1'b0);

        // Asynchronous reset with rows in flight and buffered
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'(i + 1), makeRow(400 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idleStep(1'b1, 1'b0);
        idleStep(1'b1, 1'b0);
        #3;
        bus.in_valid     = 1'b0;
        bus.sm_valid_out = 1'b0;
        bus.out_ready    = 1'b0;
        rst_n            = 1'b0;
        #1;
        checkOutput("rst_out_valid", XW'(bus.out_valid), XW'(0));
        checkOutput("rst_in_ready", XW'(bus.in_ready), XW'(0));
        checkOutput("rst_busy", XW'(busy), XW'(0));
        checkOutput("rst_sm_en", XW'(bus.sm_en), XW'(0));
        checkOutput("rst_err_ovf", XW'(errOvf), XW'(0));
        checkOutput("rst_sm_valid_in", XW'(bus.sm_valid_in), XW'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        idleStep(1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd9, makeRow(500), 1'b0, 1'b0, 1'b0, 1'b0);
        idleStep(1'b0, 1'b0);
        idleStep(1'b1, 1'b0);
        idleStep(1'b0, 1'b1);
        idleStep(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
